// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- main control FSM for the multicycle MIPS datapath.
//
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath enables, mux selects and ALU operation.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   Op, Funct           IR[31:26] and IR[5:0]
//   Zero                ALU zero flag (combinational, current cycle)
//   MemReady            memory completes the access this cycle
//   PCWr, IRWr          PC / instruction register load enables
//   MemRd, MemWr, IorD  memory requests and address select (0=PC, 1=ALUOut)
//   RegWr, RegDst, WbSel  register file write, dest select, write-data select
//   ALUSrcA, ALUSrcB    ALU operand selects
//   PCSrc               next-PC select
//   ALUOp               ALU operation (ALUOP_* encoding)
//   State               current state (FETCH=0 .. WB=4)
//   IllegalInstr        one-cycle pulse in DECODE for an unsupported instruction

package aluop_pkg;
    localparam logic [5:0] ALUOP_ADD  = 6'd0;
    localparam logic [5:0] ALUOP_ADDU = 6'd1;
    localparam logic [5:0] ALUOP_SUB  = 6'd2;
    localparam logic [5:0] ALUOP_SUBU = 6'd3;
    localparam logic [5:0] ALUOP_AND  = 6'd4;
    localparam logic [5:0] ALUOP_OR   = 6'd5;
    localparam logic [5:0] ALUOP_XOR  = 6'd6;
    localparam logic [5:0] ALUOP_NOR  = 6'd7;
    localparam logic [5:0] ALUOP_SLT  = 6'd8;
    localparam logic [5:0] ALUOP_SLTU = 6'd9;
    localparam logic [5:0] ALUOP_SLL  = 6'd10;
    localparam logic [5:0] ALUOP_SRL  = 6'd11;
    localparam logic [5:0] ALUOP_SRA  = 6'd12;
    localparam logic [5:0] ALUOP_SLLV = 6'd13;
    localparam logic [5:0] ALUOP_SRLV = 6'd14;
    localparam logic [5:0] ALUOP_SRAV = 6'd15;
    localparam logic [5:0] ALUOP_ANDI = 6'd16;
    localparam logic [5:0] ALUOP_ORI  = 6'd17;
    localparam logic [5:0] ALUOP_XORI = 6'd18;
    localparam logic [5:0] ALUOP_LUI  = 6'd19;
endpackage

module multicycle_ctrl
    import aluop_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWr,
    output logic       IRWr,
    output logic       MemRd,
    output logic       MemWr,
    output logic       IorD,
    output logic       RegWr,
    output logic [1:0] RegDst,
    output logic [1:0] WbSel,
    output logic [1:0] ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [5:0] ALUOp,
    output logic [2:0] State,
    output logic       IllegalInstr
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_RALU, C_SHIFT, C_IALU, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR
    } cls_t;

    // Instruction class from the opcode/funct held in IR.
    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] funct);
        cls_t c;
        c = C_ILL;
        case (op)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03: c = C_SHIFT;
                    6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B:        c = C_RALU;
                    6'h08:               c = C_JR;
                    default:             c = C_ILL;
                endcase
            end
            6'h02:                       c = C_J;
            6'h03:                       c = C_JAL;
            6'h04, 6'h05:                c = C_BR;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F:  c = C_IALU;
            6'h23:                       c = C_LW;
            6'h2B:                       c = C_SW;
            default:                     c = C_ILL;
        endcase
        return c;
    endfunction

    // ALU operation used in EXEC; anything not listed computes an address (ADD).
    function automatic logic [5:0] exec_aluop(input logic [5:0] op, input logic [5:0] funct);
        logic [5:0] a;
        a = ALUOP_ADD;
        if (op == 6'h00) begin
            case (funct)
                6'h00: a = ALUOP_SLL;
                6'h02: a = ALUOP_SRL;
                6'h03: a = ALUOP_SRA;
                6'h04: a = ALUOP_SLLV;
                6'h06: a = ALUOP_SRLV;
                6'h07: a = ALUOP_SRAV;
                6'h20: a = ALUOP_ADD;
                6'h21: a = ALUOP_ADDU;
                6'h22: a = ALUOP_SUB;
                6'h23: a = ALUOP_SUBU;
                6'h24: a = ALUOP_AND;
                6'h25: a = ALUOP_OR;
                6'h26: a = ALUOP_XOR;
                6'h27: a = ALUOP_NOR;
                6'h2A: a = ALUOP_SLT;
                6'h2B: a = ALUOP_SLTU;
                default: a = ALUOP_ADD;
            endcase
        end else begin
            case (op)
                6'h04, 6'h05: a = ALUOP_SUB;
                6'h08: a = ALUOP_ADD;
                6'h09: a = ALUOP_ADDU;
                6'h0A: a = ALUOP_SLT;
                6'h0B: a = ALUOP_SLTU;
                6'h0C: a = ALUOP_ANDI;
                6'h0D: a = ALUOP_ORI;
                6'h0E: a = ALUOP_XORI;
                6'h0F: a = ALUOP_LUI;
                default: a = ALUOP_ADD;
            endcase
        end
        return a;
    endfunction

    state_t state_q, state_d;
    cls_t   cls;

    assign cls   = classify(Op, Funct);
    assign State = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: state_d = (cls == C_ILL) ? S_FETCH : S_EXEC;
            S_EXEC: begin
                case (cls)
                    C_LW, C_SW:              state_d = S_MEM;
                    C_RALU, C_SHIFT, C_IALU: state_d = S_WB;
                    default:                 state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (!MemReady)        state_d = S_MEM;
                else if (cls == C_LW) state_d = S_WB;
                else                  state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWr         = 1'b0;
        IRWr         = 1'b0;
        MemRd        = 1'b0;
        MemWr        = 1'b0;
        IorD         = 1'b0;
        RegWr        = 1'b0;
        RegDst       = 2'd0;
        WbSel        = 2'd0;
        ALUSrcA      = 2'd0;
        ALUSrcB      = 3'd0;
        PCSrc        = 2'd0;
        ALUOp        = ALUOP_ADD;
        IllegalInstr = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRd   = 1'b1;
                ALUSrcB = 3'd1;
                PCWr    = MemReady;
                IRWr    = MemReady;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                ALUSrcB      = 3'd4;
                IllegalInstr = (cls == C_ILL);
            end
            S_EXEC: begin
                ALUOp = exec_aluop(Op, Funct);
                case (cls)
                    C_RALU: ALUSrcA = 2'd1;
                    C_SHIFT: ALUSrcA = 2'd2;
                    C_IALU: begin
                        ALUSrcA = 2'd1;
                        // Logical immediates and lui are zero-extended.
                        ALUSrcB = (Op[3:2] == 2'b11) ? 3'd3 : 3'd2;
                    end
                    C_LW, C_SW: begin
                        ALUSrcA = 2'd1;
                        ALUSrcB = 3'd2;
                    end
                    C_BR: begin
                        ALUSrcA = 2'd1;
                        PCSrc   = 2'd1;
                        // Op[0] distinguishes bne from beq.
                        PCWr    = Op[0] ? !Zero : Zero;
                    end
                    C_J: begin
                        PCSrc = 2'd2;
                        PCWr  = 1'b1;
                    end
                    C_JAL: begin
                        // PC already holds PC+4; it is written to $31 on the
                        // same edge that loads the jump target.
                        PCSrc  = 2'd2;
                        PCWr   = 1'b1;
                        RegWr  = 1'b1;
                        RegDst = 2'd2;
                        WbSel  = 2'd2;
                    end
                    C_JR: begin
                        PCSrc = 2'd3;
                        PCWr  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                IorD  = 1'b1;
                MemRd = (cls == C_LW);
                MemWr = (cls == C_SW);
            end
            S_WB: begin
                RegWr = 1'b1;
                case (cls)
                    C_LW:              WbSel  = 2'd1;
                    C_RALU, C_SHIFT:   RegDst = 2'd1;
                    default: ;
                endcase
            end
            default: ;
        endcase
        // Reset suppresses every request and write so an aborted instruction
        // leaves no side effect.
        if (!rst_n) begin
            PCWr         = 1'b0;
            IRWr         = 1'b0;
            RegWr        = 1'b0;
            MemRd        = 1'b0;
            MemWr        = 1'b0;
            IllegalInstr = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction sequences with a per-cycle
// scoreboard of the full control word.
module tb_multicycle_ctrl;
    import aluop_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op, Funct;
    logic       Zero, MemReady;
    logic       PCWr, IRWr, MemRd, MemWr, IorD, RegWr, IllegalInstr;
    logic [1:0] RegDst, WbSel, ALUSrcA, PCSrc;
    logic [2:0] ALUSrcB, State;
    logic [5:0] ALUOp;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwr, irwr, memrd, memwr, iord, regwr;
        logic [1:0] regdst, wbsel, srca;
        logic [2:0] srcb;
        logic [1:0] pcsrc;
        logic [5:0] aluop;
        logic       ill;
    } obs_t;

    obs_t obs;
    obs_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic sw_watch = 1'b0;
    logic saw_memwr = 1'b0;

    assign obs = {State, PCWr, IRWr, MemRd, MemWr, IorD, RegWr, RegDst, WbSel,
                  ALUSrcA, ALUSrcB, PCSrc, ALUOp, IllegalInstr};

    always #5 clk = ~clk;

    always @(posedge MemWr) if (sw_watch) saw_memwr = 1'b1;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .PCWr(PCWr), .IRWr(IRWr), .MemRd(MemRd),
        .MemWr(MemWr), .IorD(IorD), .RegWr(RegWr), .RegDst(RegDst),
        .WbSel(WbSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .ALUOp(ALUOp), .State(State), .IllegalInstr(IllegalInstr)
    );

    function automatic obs_t base(input logic [2:0] st);
        obs_t e;
        e = '0;
        e.st = st;
        e.aluop = ALUOP_ADD;
        return e;
    endfunction

    function automatic obs_t e_fetch(input logic rdy);
        obs_t e;
        e = base(3'd0);
        e.memrd = 1'b1;
        e.srcb = 3'd1;
        e.pcwr = rdy;
        e.irwr = rdy;
        return e;
    endfunction

    function automatic obs_t e_reset();
        obs_t e;
        e = base(3'd0);
        e.srcb = 3'd1;
        return e;
    endfunction

    function automatic obs_t e_decode(input logic ill);
        obs_t e;
        e = base(3'd1);
        e.srcb = 3'd4;
        e.ill = ill;
        return e;
    endfunction

    function automatic obs_t e_exec(input logic [1:0] srca, input logic [2:0] srcb,
                                    input logic [5:0] aluop);
        obs_t e;
        e = base(3'd2);
        e.srca = srca;
        e.srcb = srcb;
        e.aluop = aluop;
        return e;
    endfunction

    function automatic obs_t e_mem(input logic is_lw);
        obs_t e;
        e = base(3'd3);
        e.iord = 1'b1;
        e.memrd = is_lw;
        e.memwr = !is_lw;
        return e;
    endfunction

    function automatic obs_t e_wb(input logic [1:0] regdst, input logic [1:0] wbsel);
        obs_t e;
        e = base(3'd4);
        e.regwr = 1'b1;
        e.regdst = regdst;
        e.wbsel = wbsel;
        return e;
    endfunction

    task automatic check(input string tag);
        obs_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $error("FAIL %s scoreboard empty, observed %h", tag, obs);
        end else begin
            e = q.pop_front();
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, record the expected
    // control word, compare once the combinational outputs have settled.
    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic rdy, input obs_t e, input string tag);
        @(negedge clk);
        Op = op; Funct = fn; Zero = z; MemReady = rdy;
        q.push_back(e);
        #1;
        check(tag);
    endtask

    obs_t x;

    initial begin
        rst_n = 1'b0; Op = 6'h00; Funct = 6'h21; Zero = 1'b0; MemReady = 1'b1;
        @(negedge clk);
        q.push_back(e_reset());
        #1 check("reset_hold");
        @(posedge clk); #2 rst_n = 1'b1;

        // addu: 0,1,2,4,0
        cyc(6'h00, 6'h21, 0, 1, e_fetch(1), "addu_fetch");
        cyc(6'h00, 6'h21, 0, 1, e_decode(0), "addu_decode");
        cyc(6'h00, 6'h21, 0, 1, e_exec(2'd1, 3'd0, ALUOP_ADDU), "addu_exec");
        cyc(6'h00, 6'h21, 0, 1, e_wb(2'd1, 2'd0), "addu_wb");

        // lw with two wait cycles in MEM: 7 cycles total
        cyc(6'h23, 6'h00, 0, 1, e_fetch(1), "lw_fetch");
        cyc(6'h23, 6'h00, 0, 1, e_decode(0), "lw_decode");
        cyc(6'h23, 6'h00, 0, 1, e_exec(2'd1, 3'd2, ALUOP_ADD), "lw_exec");
        cyc(6'h23, 6'h00, 0, 0, e_mem(1), "lw_mem_wait1");
        cyc(6'h23, 6'h00, 0, 0, e_mem(1), "lw_mem_wait2");
        cyc(6'h23, 6'h00, 0, 1, e_mem(1), "lw_mem_ready");
        cyc(6'h23, 6'h00, 0, 1, e_wb(2'd0, 2'd1), "lw_wb");

        // beq taken, with one stalled fetch first
        cyc(6'h04, 6'h00, 1, 0, e_fetch(0), "beq_fetch_stall");
        cyc(6'h04, 6'h00, 1, 1, e_fetch(1), "beq_fetch");
        cyc(6'h04, 6'h00, 1, 1, e_decode(0), "beq_decode");
        x = e_exec(2'd1, 3'd0, ALUOP_SUB); x.pcsrc = 2'd1; x.pcwr = 1'b1;
        cyc(6'h04, 6'h00, 1, 1, x, "beq_z1_exec");

        // beq not taken
        cyc(6'h04, 6'h00, 0, 1, e_fetch(1), "beq0_fetch");
        cyc(6'h04, 6'h00, 0, 1, e_decode(0), "beq0_decode");
        x = e_exec(2'd1, 3'd0, ALUOP_SUB); x.pcsrc = 2'd1;
        cyc(6'h04, 6'h00, 0, 1, x, "beq_z0_exec");

        // bne with Zero=0 is taken
        cyc(6'h05, 6'h00, 0, 1, e_fetch(1), "bne_fetch");
        cyc(6'h05, 6'h00, 0, 1, e_decode(0), "bne_decode");
        x = e_exec(2'd1, 3'd0, ALUOP_SUB); x.pcsrc = 2'd1; x.pcwr = 1'b1;
        cyc(6'h05, 6'h00, 0, 1, x, "bne_z0_exec");

        // jal
        cyc(6'h03, 6'h00, 0, 1, e_fetch(1), "jal_fetch");
        cyc(6'h03, 6'h00, 0, 1, e_decode(0), "jal_decode");
        x = base(3'd2); x.pcsrc = 2'd2; x.pcwr = 1'b1; x.regwr = 1'b1;
        x.regdst = 2'd2; x.wbsel = 2'd2;
        cyc(6'h03, 6'h00, 0, 1, x, "jal_exec");

        // illegal opcode: pulse in DECODE, straight back to FETCH
        cyc(6'h3F, 6'h00, 0, 1, e_fetch(1), "ill_fetch");
        cyc(6'h3F, 6'h00, 0, 1, e_decode(1), "ill_decode");
        cyc(6'h3F, 6'h00, 0, 1, e_fetch(1), "ill_back_fetch");

        // illegal funct under Op=0
        cyc(6'h00, 6'h3F, 0, 1, e_decode(1), "illfn_decode");

        // sll (shift-immediate)
        cyc(6'h00, 6'h00, 0, 1, e_fetch(1), "sll_fetch");
        cyc(6'h00, 6'h00, 0, 1, e_decode(0), "sll_decode");
        cyc(6'h00, 6'h00, 0, 1, e_exec(2'd2, 3'd0, ALUOP_SLL), "sll_exec");
        cyc(6'h00, 6'h00, 0, 1, e_wb(2'd1, 2'd0), "sll_wb");

        // ori (zero-extended immediate)
        cyc(6'h0D, 6'h00, 0, 1, e_fetch(1), "ori_fetch");
        cyc(6'h0D, 6'h00, 0, 1, e_decode(0), "ori_decode");
        cyc(6'h0D, 6'h00, 0, 1, e_exec(2'd1, 3'd3, ALUOP_ORI), "ori_exec");
        cyc(6'h0D, 6'h00, 0, 1, e_wb(2'd0, 2'd0), "ori_wb");

        // jr
        cyc(6'h00, 6'h08, 0, 1, e_fetch(1), "jr_fetch");
        cyc(6'h00, 6'h08, 0, 1, e_decode(0), "jr_decode");
        x = base(3'd2); x.pcsrc = 2'd3; x.pcwr = 1'b1;
        cyc(6'h00, 6'h08, 0, 1, x, "jr_exec");

        // sw aborted by reset in EXEC
        sw_watch = 1'b1;
        cyc(6'h2B, 6'h00, 0, 1, e_fetch(1), "sw_fetch");
        cyc(6'h2B, 6'h00, 0, 1, e_decode(0), "sw_decode");
        cyc(6'h2B, 6'h00, 0, 1, e_exec(2'd1, 3'd2, ALUOP_ADD), "sw_exec");
        #2 rst_n = 1'b0;
        q.push_back(e_reset());
        #1 check("sw_async_reset");
        @(negedge clk);
        q.push_back(e_reset());
        #1 check("sw_reset_held");
        @(posedge clk); #2 rst_n = 1'b1;
        cyc(6'h2B, 6'h00, 0, 1, e_fetch(1), "post_reset_fetch");
        sw_watch = 1'b0;
        tests++;
        assert (saw_memwr === 1'b0) else begin
            fails++;
            $error("FAIL sw_no_memwr observed %b expected %b", saw_memwr, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
